// File: rtl/pll_reset_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_rst_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    HOLD      = 3'd2,
    RUN       = 3'd3,
    LOST      = 3'd4
  } state_e;

  localparam int unsigned LOSS_COUNT_W = 8;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pll_reset_seq_if.sv
// Lock input and reset/status outputs of the PLL reset sequencer.
interface pll_reset_seq_if;
  import pll_rst_pkg::*;

  logic                    pll_lock;
  logic                    rst_out;
  logic                    ready;
  logic [LOSS_COUNT_W-1:0] loss_count;

  modport master (output pll_lock, input rst_out, input ready, input loss_count);
  modport slave  (input pll_lock, output rst_out, output ready, output loss_count);
endinterface

// File: rtl/pll_reset_seq_sync_2ff.sv
// Two-flop synchroniser with synchronous clear, for any asynchronous level input.
module sync_2ff (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/pll_reset_seq.sv
// Qualifies PLL lock and sequences the downstream video reset.
// Optional loss counter enabled by defining PLL_RESET_SEQ_LOSS_COUNT_EN.
module pll_reset_seq
  import pll_rst_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES   = 16000,
  parameter int unsigned RST_HOLD_CYCLES      = 16,
  parameter int unsigned GLITCH_FILTER_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  pll_reset_seq_if.slave  bus
);

  localparam int unsigned CNT_MAX = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ?
                                    LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
  localparam int unsigned CNT_W   = cnt_width(CNT_MAX);
  localparam int unsigned GCNT_W  = cnt_width(GLITCH_FILTER_CYCLES);

  localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [GCNT_W-1:0] GLITCH_LAST = GCNT_W'(GLITCH_FILTER_CYCLES - 1);

  logic lock_s;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
  logic              rst_out_q, rst_out_d;
  logic              ready_q, ready_d;
  logic              loss_inc;

  sync_2ff u_sync (
    .clk (clk),
    .clr (reset),
    .d   (bus.pll_lock),
    .q   (lock_s)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gcnt_d   = gcnt_q;
    loss_inc = 1'b0;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          gcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (lock_s) begin
          gcnt_d = '0;
        end else if (gcnt_q == GLITCH_LAST) begin
          state_d = LOST;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      LOST: begin
        state_d  = WAIT_LOCK;
        loss_inc = 1'b1;
      end
      default: state_d = WAIT_LOCK;
    endcase
    // Outputs follow the next state so they change on the same edge as the FSM.
    rst_out_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      gcnt_q    <= '0;
      rst_out_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gcnt_q    <= gcnt_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.rst_out = rst_out_q;
  assign bus.ready   = ready_q;

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  logic [LOSS_COUNT_W-1:0] loss_count_q, loss_count_d;

  always_comb begin
    loss_count_d = loss_count_q;
    if (loss_inc && (loss_count_q != '1)) begin
      loss_count_d = loss_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      loss_count_q <= '0;
    end else begin
      loss_count_q <= loss_count_d;
    end
  end

  assign bus.loss_count = loss_count_q;
`else
  logic unused_loss_inc;
  assign unused_loss_inc = loss_inc;
  assign bus.loss_count  = '0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with LOCK_STABLE=8, RST_HOLD=4, GLITCH_FILTER=3.
module tb_pll_reset_seq;
  import pll_rst_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   errors     = 0;
  int   checks     = 0;
  int   loss_model = 0;

  pll_reset_seq_if bus ();

  pll_reset_seq #(
    .LOCK_STABLE_CYCLES   (8),
    .RST_HOLD_CYCLES      (4),
    .GLITCH_FILTER_CYCLES (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Drive pll_lock for one edge, then sample 1 time unit after that edge.
  task automatic step(input logic lock);
    bus.pll_lock = lock;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_loss();
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    return (loss_model > 255) ? 255 : loss_model;
`else
    return 0;
`endif
  endfunction

  // Edge 0 is the first edge sampling pll_lock=1; release happens on edge 14.
  task automatic qualify(input string tag);
    for (int k = 0; k < 14; k++) begin
      step(1'b1);
      chk({tag, "_rst_hi"}, 32'(bus.rst_out), 32'd1);
      chk({tag, "_rdy_lo"}, 32'(bus.ready), 32'd0);
    end
    step(1'b1);
    chk({tag, "_rst_lo"}, 32'(bus.rst_out), 32'd0);
    chk({tag, "_rdy_hi"}, 32'(bus.ready), 32'd1);
    chk({tag, "_loss"}, 32'(bus.loss_count), 32'(exp_loss()));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bus.pll_lock = 1'b1;
    reset = 1'b1;
    repeat (3) step(1'b1);
    chk("reset_rst", 32'(bus.rst_out), 32'd1);
    chk("reset_rdy", 32'(bus.ready), 32'd0);
    chk("reset_loss", 32'(bus.loss_count), 32'd0);

    reset = 1'b0;
    qualify("init");

    // Two-cycle low pulse is below the glitch window.
    step(1'b0);
    step(1'b0);
    for (int k = 0; k < 6; k++) begin
      step(1'b1);
      chk("glitch_rst", 32'(bus.rst_out), 32'd0);
      chk("glitch_rdy", 32'(bus.ready), 32'd1);
    end
    chk("glitch_loss", 32'(bus.loss_count), 32'(exp_loss()));

    // Five-cycle low: reset rises on edge d0+4.
    for (int k = 0; k < 4; k++) begin
      step(1'b0);
      chk("loss_rst_pre", 32'(bus.rst_out), 32'd0);
    end
    step(1'b0);
    chk("loss_rst_d4", 32'(bus.rst_out), 32'd1);
    chk("loss_rdy_d4", 32'(bus.ready), 32'd0);
    chk("loss_cnt_d4", 32'(bus.loss_count), 32'(exp_loss()));
    loss_model++;
    qualify("reloss");

    // Drop in STABLE at cnt=5 restarts the whole window.
    for (int k = 0; k < 5; k++) step(1'b0);
    loss_model++;
    for (int k = 0; k < 6; k++) step(1'b1);
    step(1'b0);
    qualify("stable_drop");

    // One-cycle reset while in RUN.
    reset = 1'b1;
    step(1'b1);
    loss_model = 0;
    chk("midrst_rst", 32'(bus.rst_out), 32'd1);
    chk("midrst_rdy", 32'(bus.ready), 32'd0);
    chk("midrst_loss", 32'(bus.loss_count), 32'd0);
    reset = 1'b0;
    qualify("requal");

    // Repeated losses drive the counter into saturation.
    for (int i = 0; i < 300; i++) begin
      repeat (5) step(1'b0);
      loss_model++;
      repeat (15) step(1'b1);
      if (i == 254 || i == 255 || i == 299) begin
        chk("sat_rdy", 32'(bus.ready), 32'd1);
        chk("sat_loss", 32'(bus.loss_count), 32'(exp_loss()));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
